// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone RAM arbiter.
package wb_arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    TOERR = 2'd2
  } arb_state_t;

  // Master slots on the shared RAM port
  localparam int CPU_M = 0;
  localparam int DSP_M = 1;
  localparam int DAQ_M = 2;

  // Watchdog counter width; bounds the usable TIMEOUT range
  localparam int WDT_W = 16;

  // Index width for a requester vector; at least one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Candidate slot visited at distance 'off' past 'last', wrapping modulo n
  function automatic int rr_slot(input int last, input int off, input int n);
    return (last + off) % n;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: first requester after i_last wins.
module wb_arb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_oh,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] w_slot;

  // Walk last+1 .. last+N (wrapping); the first set request takes the grant
  always_comb begin
    o_oh    = '0;
    o_idx   = i_last;
    o_valid = 1'b0;
    w_slot  = '0;
    for (int k = 1; k <= N; k++) begin
      w_slot = IW'(rr_slot(int'(i_last), k, N));
      if (!o_valid && i_req[w_slot]) begin
        o_oh[w_slot] = 1'b1;
        o_idx        = w_slot;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone arbiter in front of the shared SRAM slave port.
// One master owns the port for a whole CYC; a watchdog breaks hung strobes.
module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst,
  // master side
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  // slave side
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,
  // status
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int                N      = NUM_MASTERS;
  localparam int                SW     = DW / 8;
  localparam int                IW     = idx_w(N);
  localparam logic [WDT_W-1:0]  TO_CNT = WDT_W'(TIMEOUT);

  arb_state_t       r_state, w_state_nxt;
  logic [N-1:0]     r_grant, w_grant_nxt;
  logic [IW-1:0]    r_last,  w_last_nxt;
  logic [WDT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [WDT_W-1:0] w_cnt_inc;

  logic [N-1:0]     w_pick_oh;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_vld;

  logic [AW-1:0]    w_adr;
  logic [DW-1:0]    w_dat;
  logic [SW-1:0]    w_sel;
  logic [2:0]       w_cti;
  logic [1:0]       w_bte;
  logic             w_gnt_cyc, w_gnt_stb, w_gnt_we;
  logic             w_busy, w_toerr;
  logic             w_resp, w_stall, w_fire;

  wb_arb_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .i_req   (m_cyc_i),
    .i_last  (r_last),
    .o_oh    (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  assign w_busy  = (r_state == BUSY);
  assign w_toerr = (r_state == TOERR);

  // AND-OR mux of the granted master's request; all zero with no grant
  always_comb begin
    w_adr     = '0;
    w_dat     = '0;
    w_sel     = '0;
    w_cti     = '0;
    w_bte     = '0;
    w_gnt_cyc = 1'b0;
    w_gnt_stb = 1'b0;
    w_gnt_we  = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_adr     = w_adr | ({AW{r_grant[i]}} & m_adr_i[i*AW +: AW]);
      w_dat     = w_dat | ({DW{r_grant[i]}} & m_dat_i[i*DW +: DW]);
      w_sel     = w_sel | ({SW{r_grant[i]}} & m_sel_i[i*SW +: SW]);
      w_cti     = w_cti | ({3{r_grant[i]}}  & m_cti_i[i*3 +: 3]);
      w_bte     = w_bte | ({2{r_grant[i]}}  & m_bte_i[i*2 +: 2]);
      w_gnt_cyc = w_gnt_cyc | (r_grant[i] & m_cyc_i[i]);
      w_gnt_stb = w_gnt_stb | (r_grant[i] & m_stb_i[i]);
      w_gnt_we  = w_gnt_we  | (r_grant[i] & m_we_i[i]);
    end
  end

  // Slave port: cyc/stb are withheld in TOERR so the hung access is abandoned
  assign s_adr_o = w_adr;
  assign s_dat_o = w_dat;
  assign s_sel_o = w_sel;
  assign s_cti_o = w_cti;
  assign s_bte_o = w_bte;
  assign s_we_o  = w_gnt_we;
  assign s_cyc_o = w_busy & w_gnt_cyc;
  assign s_stb_o = w_busy & w_gnt_stb;

  // Responses go only to the granted master; read data is broadcast
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = w_busy ? (r_grant & {N{s_ack_i}}) : '0;
  assign m_rty_o   = w_busy ? (r_grant & {N{s_rty_i}}) : '0;
  assign m_err_o   = w_toerr ? r_grant :
                     w_busy  ? (r_grant & {N{s_err_i}}) : '0;
  assign grant_o   = r_grant;
  assign timeout_o = w_toerr;

  // Watchdog: fires on the stalled cycle whose increment would reach TIMEOUT,
  // so a response in that same cycle still wins
  assign w_resp    = s_ack_i | s_err_i | s_rty_i;
  assign w_stall   = w_busy & s_stb_o & ~w_resp;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_fire    = w_stall & (w_cnt_inc == TO_CNT);

  // Next-state, grant and watchdog logic
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_grant_nxt = w_pick_oh;
          w_last_nxt  = w_pick_idx;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!w_gnt_cyc) begin
          w_grant_nxt = '0;
          w_state_nxt = IDLE;
        end else if (w_fire) begin
          w_state_nxt = TOERR;
        end else if (w_stall) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      TOERR: begin
        if (w_gnt_cyc) begin
          w_state_nxt = BUSY;
        end else begin
          w_grant_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State registers; reset drops any grant immediately
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IW'(N - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter with a small behavioural SRAM slave.
module tb_wb_ram_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat;
  logic [N*DW/8-1:0] m_sel;
  logic [N-1:0]      m_we, m_cyc, m_stb;
  logic [N*3-1:0]    m_cti;
  logic [N*2-1:0]    m_bte;
  logic [DW-1:0]     m_dat_o;
  logic [N-1:0]      m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic              s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i, s_rty_i;
  logic [N-1:0]      grant_o;
  logic              timeout_o;

  logic              ack_en;
  logic [31:0]       mem [16];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_ram_arbiter #(
    .NUM_MASTERS (N),
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT     (8)
  ) dut (
    .wb_clk    (clk),
    .wb_rst    (rst),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_dat),
    .m_sel_i   (m_sel),
    .m_we_i    (m_we),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_cti_i   (m_cti),
    .m_bte_i   (m_bte),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .m_rty_o   (m_rty_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_we_o    (s_we_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_cti_o   (s_cti_o),
    .s_bte_o   (s_bte_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .s_rty_i   (s_rty_i),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  // Zero-wait SRAM slave; ack can be withheld to hang a strobe
  assign s_ack_i = ack_en & s_cyc_o & s_stb_o;
  assign s_dat_i = mem[s_adr_o[5:2]];

  always @(posedge clk)
    if (s_cyc_o && s_stb_o && s_we_o && s_ack_i) mem[s_adr_o[5:2]] <= s_dat_o;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [2:0] cti, input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[i]            = cyc;
    m_stb[i]            = stb;
    m_we[i]             = we;
    m_cti[i*3 +: 3]     = cti;
    m_bte[i*2 +: 2]     = 2'b00;
    m_adr[i*AW +: AW]   = adr;
    m_dat[i*DW +: DW]   = dat;
    m_sel[i*4 +: 4]     = 4'hF;
  endtask

  initial begin
    int            beats [N];
    bit            dropped [N];
    logic [N-1:0]  acked;
    logic [N-1:0]  expg, expa;
    int            k, slot;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst = 1'b1; ack_en = 1'b1; s_err_i = 1'b0; s_rty_i = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    m_cti = '0; m_bte = '0;

    // ---- reset state
    step(); step();
    #1;
    chk("rst_grant",   grant_o,   3'b000);
    chk("rst_scyc",    s_cyc_o,   1'b0);
    chk("rst_sstb",    s_stb_o,   1'b0);
    chk("rst_sadr",    s_adr_o,   32'h0);
    chk("rst_ack",     m_ack_o,   3'b000);
    chk("rst_err",     m_err_o,   3'b000);
    chk("rst_rty",     m_rty_o,   3'b000);
    chk("rst_to",      timeout_o, 1'b0);
    chk("rst_mdat",    m_dat_o,   32'h0);
    rst = 1'b0;
    step();

    // ---- reset in the middle of a DSP burst
    drive(1, 1, 1, 0, 3'b010, 32'h80, 0);
    step();
    #1 chk("dsp_grant", grant_o, 3'b010);
    step();
    #1 rst = 1'b1;
    #1;
    chk("midrst_grant", grant_o,   3'b000);
    chk("midrst_scyc",  s_cyc_o,   1'b0);
    chk("midrst_err",   m_err_o,   3'b000);
    chk("midrst_to",    timeout_o, 1'b0);
    drive(0, 1, 1, 0, 3'b000, 32'h10, 0);
    step();
    rst = 1'b0;
    step();
    #1;
    chk("postrst_grant", grant_o, 3'b001);
    chk("postrst_scyc",  s_cyc_o, 1'b1);
    drive(0, 0, 0, 0, 3'b000, 0, 0);
    drive(1, 0, 0, 0, 3'b000, 0, 0);
    step(); step();
    #1 chk("postrst_idle", grant_o, 3'b000);

    // ---- CPU single write then read back
    drive(0, 1, 1, 1, 3'b000, 32'h10, 32'hDEADBEEF);
    step();
    #1;
    chk("wr_grant", grant_o, 3'b001);
    chk("wr_ack",   m_ack_o, 3'b001);
    chk("wr_sadr",  s_adr_o, 32'h10);
    chk("wr_sdat",  s_dat_o, 32'hDEADBEEF);
    chk("wr_swe",   s_we_o,  1'b1);
    chk("wr_ssel",  s_sel_o, 4'hF);
    step();
    drive(0, 0, 0, 0, 3'b000, 0, 0);
    step();
    #1 chk("wr_idle", grant_o, 3'b000);
    drive(0, 1, 1, 0, 3'b000, 32'h10, 0);
    step();
    #1;
    chk("rd_mdat", m_dat_o, 32'hDEADBEEF);
    chk("rd_ack",  m_ack_o, 3'b001);
    chk("rd_swe",  s_we_o,  1'b0);
    step();
    drive(0, 0, 0, 0, 3'b000, 0, 0);
    step();

    // ---- contention: reset restores last_grant so the CPU goes first
    rst = 1'b1;
    #1 chk("rst2_grant", grant_o, 3'b000);
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < N; i++) begin
      drive(i, 1, 1, 0, 3'b010, 32'h100 * (i + 1), 0);
      beats[i] = 0; dropped[i] = 1'b0;
    end
    acked = '0;
    // 4 acked beats, one granted cycle after release, one dead cycle
    for (int c = 1; c <= 24; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (dropped[i]) begin
          drive(i, 1, 1, 0, 3'b010, 32'h100 * (i + 1), 0);
          dropped[i] = 1'b0;
          beats[i]   = 0;
        end else if (acked[i]) begin
          beats[i]++;
          if (beats[i] == 4) begin
            drive(i, 0, 0, 0, 3'b000, 0, 0);
            dropped[i] = 1'b1;
          end
        end
      end
      #1;
      k    = (c - 1) % 6;
      slot = ((c - 1) / 6) % 3;
      expg = (k == 5) ? 3'b000 : (3'b001 << slot);
      expa = (k < 4)  ? expg   : 3'b000;
      chk($sformatf("cont_grant_c%0d", c), grant_o, expg);
      chk($sformatf("cont_ack_c%0d", c),   m_ack_o, expa);
      acked = m_ack_o;
    end
    for (int i = 0; i < N; i++) drive(i, 0, 0, 0, 3'b000, 0, 0);
    step();
    #1 chk("cont_idle", grant_o, 3'b000);

    // ---- DAQ 8-beat incrementing burst holds the port against the CPU
    drive(2, 1, 1, 0, 3'b010, 32'h20, 0);
    step();
    drive(0, 1, 1, 0, 3'b000, 32'h10, 0);
    for (int b = 1; b <= 8; b++) begin
      #1;
      chk($sformatf("burst_grant_b%0d", b), grant_o, 3'b100);
      chk($sformatf("burst_ack_b%0d", b),   m_ack_o, 3'b100);
      chk($sformatf("burst_adr_b%0d", b),   s_adr_o, 32'h20 + 32'(4 * (b - 1)));
      chk($sformatf("burst_cti_b%0d", b),   s_cti_o, (b == 8) ? 3'b111 : 3'b010);
      step();
      if (b < 8) drive(2, 1, 1, 0, (b == 7) ? 3'b111 : 3'b010, 32'h20 + 32'(4 * b), 0);
    end
    drive(2, 0, 0, 0, 3'b000, 0, 0);
    #1 chk("burst_tail_grant", grant_o, 3'b100);
    step();
    #1 chk("burst_dead_grant", grant_o, 3'b000);
    step();
    #1;
    chk("burst_cpu_grant", grant_o, 3'b001);
    chk("burst_cpu_ack",   m_ack_o, 3'b001);
    drive(0, 0, 0, 0, 3'b000, 0, 0);
    step(); step();

    // ---- watchdog: DSP read with ack stuck low, TIMEOUT=8
    ack_en = 1'b0;
    drive(1, 1, 1, 0, 3'b000, 32'h40, 0);
    step();
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk($sformatf("wdt_to_c%0d", c),  timeout_o, 1'b0);
      chk($sformatf("wdt_stb_c%0d", c), s_stb_o,   1'b1);
      step();
    end
    #1;
    chk("wdt_to_c9",   timeout_o, 1'b1);
    chk("wdt_err_c9",  m_err_o,   3'b010);
    chk("wdt_stb_c9",  s_stb_o,   1'b0);
    chk("wdt_cyc_c9",  s_cyc_o,   1'b0);
    chk("wdt_gnt_c9",  grant_o,   3'b010);
    step();
    #1;
    chk("wdt_to_c10",  timeout_o, 1'b0);
    chk("wdt_err_c10", m_err_o,   3'b000);
    chk("wdt_stb_c10", s_stb_o,   1'b1);

    // ---- race: ack lands on the stall cycle that would have fired
    for (int c = 1; c <= 7; c++) begin
      #1 chk($sformatf("race_to_c%0d", c), timeout_o, 1'b0);
      step();
    end
    ack_en = 1'b1;
    #1;
    chk("race_ack",  m_ack_o,   3'b010);
    chk("race_err",  m_err_o,   3'b000);
    chk("race_to",   timeout_o, 1'b0);
    step();
    ack_en = 1'b0;
    #1;
    chk("race_to_after",  timeout_o, 1'b0);
    chk("race_err_after", m_err_o,   3'b000);
    chk("race_stb_after", s_stb_o,   1'b1);

    // ---- counter restarted by the ack: fires 8 stalls later; DSP gives up
    for (int c = 1; c <= 8; c++) begin
      #1 chk($sformatf("wdt2_to_c%0d", c), timeout_o, 1'b0);
      step();
    end
    #1;
    chk("wdt2_to",  timeout_o, 1'b1);
    chk("wdt2_err", m_err_o,   3'b010);
    drive(1, 0, 0, 0, 3'b000, 0, 0);
    step();
    #1;
    chk("wdt2_idle_grant", grant_o,   3'b000);
    chk("wdt2_idle_to",    timeout_o, 1'b0);
    chk("wdt2_idle_err",   m_err_o,   3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_ram_arbiter.md
# wb_ram_arbiter

Round-robin Wishbone arbiter sharing one slave port, the wb_ram0 SRAM, among the CPU master, the DSP master and the DAQ master. It sits between the master-side intercon outputs and the RAM. It grants one master per bus cycle, holds the grant for the whole CYC (including CTI bursts), and breaks hung cycles with a watchdog-generated error.

## Interface
Parameters:
- NUM_MASTERS, 3: number of requesters; index 0=CPU, 1=DSP, 2=DAQ.
- AW, 32: address width.
- DW, 32: data width; SEL width is DW/8.
- TIMEOUT, 255: cycles a strobe may wait for a response before the watchdog fires; legal range 1..65535.

Ports (master buses are flattened, with master i occupying slice [i*W +: W]):
- wb_clk  in  1  bus clock; the block's only clock.
- wb_rst  in  1  reset, asynchronous and active-high.
- m_adr_i  in  NUM_MASTERS*AW  master addresses.
- m_dat_i  in  NUM_MASTERS*DW  master write data.
- m_sel_i  in  NUM_MASTERS*DW/8  byte selects.
- m_we_i, m_cyc_i, m_stb_i  in  NUM_MASTERS each  write enable, cycle, strobe.
- m_cti_i  in  NUM_MASTERS*3  cycle type.
- m_bte_i  in  NUM_MASTERS*2  burst type.
- m_dat_o  out  DW  slave read data, broadcast to all masters.
- m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS each  responses; only the granted bit can be 1.
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  out  slave-side copies of the granted master's signals.
- s_dat_i, s_ack_i, s_err_i, s_rty_i  in  slave response.
- grant_o  out  NUM_MASTERS  one-hot current grant, all-zero when idle.
- timeout_o  out  1  single-cycle pulse when the watchdog fires.

## Operation
- The FSM has three states: IDLE, BUSY and TOERR.
- **IDLE**
  - If any m_cyc_i bit is set, pick a winner by round-robin. The search starts at last_grant+1 and wraps modulo NUM_MASTERS.
  - Register the one-hot grant, set last_grant to the winner, and go to BUSY.
- **BUSY**
  - All s_* outputs, m_dat_o and the granted master's ack/err/rty are a combinational mux driven by the registered grant.
  - Stay in BUSY while the granted master's m_cyc_i=1.
  - When the granted m_cyc_i=0, clear the grant and go to IDLE. Requests from other masters during BUSY are ignored.
- **Watchdog**
  - A 16-bit counter, active only in BUSY, counts while s_stb_o=1 and s_ack_i|s_err_i|s_rty_i=0.
  - It clears on any response, when stb drops, and outside BUSY.
  - When the count equals TIMEOUT, go to TOERR.
- **TOERR** (lasts one cycle)
  - Force s_cyc_o=s_stb_o=0.
  - Assert m_err_o[granted]=1 and timeout_o=1.
  - Then go to BUSY if the granted master's cyc is still 1, else go to IDLE with the grant cleared. The counter restarts from 0.
- **Outputs with no grant:** all s_* outputs, m_ack_o, m_err_o and m_rty_o are 0, and m_dat_o equals s_dat_i.
- **Simultaneous events:** a slave response arriving in the same cycle the count reaches TIMEOUT wins. It is forwarded and the counter clears; no error is generated.
- **Reset values:**
  - State is IDLE and grant_o=0.
  - last_grant=NUM_MASTERS-1, so master 0 wins first.
  - Counter=0, timeout_o=0, and all outputs are 0.
- **Reset mid-cycle:** the grant is dropped immediately (asynchronously) and no error is signalled.

## Timing
- Arbitration latency: a master raising cyc in IDLE at edge N gets grant_o and s_cyc_o at edge N+1.
- The ack path from s_ack_i to m_ack_o is zero-latency combinational, and bursts pass through unchanged.
- Handover costs one dead cycle. The granted master drops cyc at edge N, the FSM is in IDLE at N+1, and the next grant appears at N+2.
- Back-to-back cycles by the same master also pay this IDLE cycle. If other masters are requesting, the round-robin passes the grant to them first.
- The watchdog fires TIMEOUT cycles after the first unanswered stb cycle. m_err_o is asserted in the following cycle.

## Structure
- Package wb_arb_pkg holds:
  - the state encoding (IDLE, BUSY, TOERR);
  - the master index constants CPU_M=0, DSP_M=1, DAQ_M=2;
  - the watchdog counter width (16).
- Sub-module wb_arb_rr_pick: a purely combinational round-robin picker.
  - Inputs: request vector and last_grant.
  - Outputs: one-hot winner and its index.
- The FSM, watchdog and muxes live in the top level.

## Test plan
- **Reset:** assert wb_rst mid-burst by the DSP → grant_o=0 and s_cyc_o=0 in the same cycle; after release, a CPU request gets a grant one cycle later.
- **Single master:** CPU writes 0xDEADBEEF to address 0x10, then reads it back → m_dat_o=0xDEADBEEF, m_ack_o=3'b001, and no ack reaches the other masters.
- **Contention:**
  - All three masters hold cyc continuously, each doing 4-beat bursts.
  - Required grant order: 001, 010, 100, 001, …
  - No interleaving inside a burst, and exactly one dead cycle between grants.
- **Burst hold:** the DAQ runs an 8-beat incrementing burst (cti=010, ending with 111) while the CPU requests → the CPU is granted only after the DAQ drops cyc.
- **Watchdog:**
  - With TIMEOUT=8, the slave's ack is stuck at 0 during a DSP read.
  - Required: timeout_o pulses at cycle 9 of stb, m_err_o=3'b010 for one cycle, and s_stb_o=0 in that cycle.
- **Race:** the slave's ack arrives in the exact cycle the count reaches TIMEOUT → ack is forwarded and no err/timeout_o occurs.
